// File: rtl/seq_rom_arb_pkg.sv
// Shared types and constants for the sequencer instruction-RAM arbiter.
// The arbiter lets the instruction-fetch master (I) and the debug/loader master (D) share one RAM port.
package seq_rom_arb_pkg;

  typedef enum logic {
    ARB     = 1'b0,
    DBG_OWN = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    TAG_I = 2'd1,
    TAG_D = 2'd2
  } rd_tag_t;

  localparam int STARVE_LIMIT_DFLT = 8;
  localparam int STARVE_W          = $clog2(STARVE_LIMIT_DFLT + 1);

endpackage

// File: rtl/seq_rom_arb_grant.sv
// Combinational grant between I and D with a starvation counter.
// The counter bounds how many consecutive I grants D can lose while it keeps requesting.
module seq_rom_arb_grant #(
  parameter  int STARVE_LIMIT = 8,
  localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic i_req,
  input  logic d_req,
  input  logic own_d,
  input  logic d_lock,
  output logic grant_i,
  output logic grant_d
);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic [CNT_W-1:0] cnt_eff;

  // Leaving debug ownership always restarts the starvation count from zero
  always_comb begin
    cnt_eff = own_d ? '0 : starve_cnt_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (en) begin
      if (own_d && d_lock) begin
        grant_d = d_req;
      end else if (i_req && d_req) begin
        if (cnt_eff == CNT_W'(STARVE_LIMIT)) grant_d = 1'b1;
        else                                 grant_i = 1'b1;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end

    starve_cnt_d = cnt_eff;
    if (!d_req || grant_d) begin
      starve_cnt_d = '0;
    end else if (grant_i && (cnt_eff != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt_d = cnt_eff + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_cnt_q <= '0;
    else          starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/blk_eb27dd.sv
// Arbiter sharing the single-port sequencer instruction RAM between the fetch master (I)
// and the debug/loader master (D): debug ownership lock, write protection, 1-cycle read return.
module blk_eb27dd
  import seq_rom_arb_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int BE_W         = DATA_W / 8,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic              i_waitrequest,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_readdatavalid,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [BE_W-1:0]   d_byteenable,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_writedata,
  input  logic              d_debugaccess,
  input  logic              d_lock,
  output logic              d_waitrequest,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_readdatavalid,
  output logic              d_write_dropped,
  input  logic              ram_wr_protect,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_debugaccess,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  arb_state_t state_q, state_d;
  rd_tag_t    rd_tag_q, rd_tag_d;
  logic       drop_q, drop_d;
  logic       grant_i, grant_d;
  logic       d_req, wr_blocked;

  assign d_req = d_read | d_write;

  // Grants are held off while reset is asserted so both masters see waitrequest=1
  seq_rom_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (reset_n),
    .i_req   (i_read),
    .d_req   (d_req),
    .own_d   (state_q == DBG_OWN),
    .d_lock  (d_lock),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB;
      rd_tag_q <= NONE;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_tag_q <= rd_tag_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (grant_d && d_lock) state_d = DBG_OWN;
      DBG_OWN: if (!d_lock)           state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // A simultaneous D read and write counts as a write only, so it gets no read return
  always_comb begin
    wr_blocked      = grant_d & d_write & ram_wr_protect;
    i_waitrequest   = ~grant_i;
    d_waitrequest   = ~grant_d;
    ram_address     = '0;
    ram_byteenable  = '0;
    ram_chipselect  = 1'b0;
    ram_clken       = 1'b0;
    ram_write       = 1'b0;
    ram_debugaccess = 1'b0;
    if (grant_i) begin
      ram_address    = i_address;
      ram_byteenable = '1;
      ram_chipselect = 1'b1;
      ram_clken      = 1'b1;
    end else if (grant_d) begin
      ram_address     = d_address;
      ram_byteenable  = d_byteenable;
      ram_chipselect  = ~wr_blocked;
      ram_clken       = ~wr_blocked;
      ram_write       = d_write & ~ram_wr_protect;
      ram_debugaccess = d_write & ~ram_wr_protect & d_debugaccess;
    end

    rd_tag_d = NONE;
    if (grant_i)                         rd_tag_d = TAG_I;
    else if (grant_d && d_read && !d_write) rd_tag_d = TAG_D;
    drop_d = wr_blocked;
  end

  assign ram_writedata   = d_writedata;
  assign i_readdata      = ram_readdata;
  assign d_readdata      = ram_readdata;
  assign i_readdatavalid = (rd_tag_q == TAG_I);
  assign d_readdatavalid = (rd_tag_q == TAG_D);
  assign d_write_dropped = drop_q;

endmodule

// File: tb/tb_blk_eb27dd.sv
// Directed bench for blk_eb27dd with a behavioural 4096x32 RAM (registered address, clken hold).
module tb_blk_eb27dd;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        i_readdatavalid;
  logic [11:0] d_address;
  logic [3:0]  d_byteenable;
  logic        d_read, d_write;
  logic [31:0] d_writedata;
  logic        d_debugaccess, d_lock;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        d_readdatavalid, d_write_dropped;
  logic        ram_wr_protect;
  logic [11:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_debugaccess, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  blk_eb27dd dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_address       (i_address),
    .i_read          (i_read),
    .i_waitrequest   (i_waitrequest),
    .i_readdata      (i_readdata),
    .i_readdatavalid (i_readdatavalid),
    .d_address       (d_address),
    .d_byteenable    (d_byteenable),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_writedata     (d_writedata),
    .d_debugaccess   (d_debugaccess),
    .d_lock          (d_lock),
    .d_waitrequest   (d_waitrequest),
    .d_readdata      (d_readdata),
    .d_readdatavalid (d_readdatavalid),
    .d_write_dropped (d_write_dropped),
    .ram_wr_protect  (ram_wr_protect),
    .ram_address     (ram_address),
    .ram_byteenable  (ram_byteenable),
    .ram_chipselect  (ram_chipselect),
    .ram_write       (ram_write),
    .ram_debugaccess (ram_debugaccess),
    .ram_writedata   (ram_writedata),
    .ram_clken       (ram_clken),
    .ram_readdata    (ram_readdata)
  );

  logic [31:0] mem [0:4095];
  logic [11:0] ram_addr_q = '0;

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      ram_addr_q <= ram_address;
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
    end
  end
  assign ram_readdata = mem[ram_addr_q];

  function automatic logic [31:0] init_word(input logic [11:0] a);
    return {8'h5A, a, ~a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; d_lock = 1'b0; ram_wr_protect = 1'b0;
  endtask

  // ir dr dw prot | iw dw cs wr | addr | iv dv drop
  typedef struct packed {
    logic ir, dr, dw, prot;
    logic exp_iw, exp_dw, exp_cs, exp_wr;
    logic [11:0] exp_addr;
    logic exp_iv, exp_dv, exp_drop;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = init_word(a[11:0]);
    tbl[0] = {4'b0000, 4'b1100, 12'h000, 3'b000};
    tbl[1] = {4'b1000, 4'b0110, 12'h0AA, 3'b100};
    tbl[2] = {4'b0100, 4'b1010, 12'h155, 3'b010};
    tbl[3] = {4'b0010, 4'b1011, 12'h155, 3'b000};
    tbl[4] = {4'b0011, 4'b1000, 12'h000, 3'b001};
    tbl[5] = {4'b1100, 4'b0110, 12'h0AA, 3'b100};
    tbl[6] = {4'b0110, 4'b1011, 12'h155, 3'b000};
    tbl[7] = {4'b1010, 4'b0110, 12'h0AA, 3'b100};

    reset_n = 1'b0;
    i_address = '0; d_address = '0; d_byteenable = 4'hF; d_writedata = '0;
    d_debugaccess = 1'b1; d_lock = 1'b0; ram_wr_protect = 1'b0;
    i_read = 1'b1; d_read = 1'b0; d_write = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_iwait", i_waitrequest, 1);
    chk("rst_dwait", d_waitrequest, 1);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_clken", ram_clken, 0);
    chk("rst_write", ram_write, 0);
    chk("rst_valids", {i_readdatavalid, d_readdatavalid, d_write_dropped}, 0);
    idle_inputs();
    reset_n = 1'b1;
    tick();

    // Single-cycle grant table
    i_address = 12'h0AA; d_address = 12'h155; d_writedata = 32'h12345678;
    for (int v = 0; v < 8; v++) begin
      i_read = tbl[v].ir; d_read = tbl[v].dr; d_write = tbl[v].dw; ram_wr_protect = tbl[v].prot;
      @(negedge clk);
      chk($sformatf("v%0d_iwait", v), i_waitrequest, tbl[v].exp_iw);
      chk($sformatf("v%0d_dwait", v), d_waitrequest, tbl[v].exp_dw);
      chk($sformatf("v%0d_cs", v), ram_chipselect, tbl[v].exp_cs);
      chk($sformatf("v%0d_clken", v), ram_clken, tbl[v].exp_cs);
      chk($sformatf("v%0d_wr", v), ram_write, tbl[v].exp_wr);
      chk($sformatf("v%0d_dbg", v), ram_debugaccess, tbl[v].exp_wr);
      if (tbl[v].exp_cs) chk($sformatf("v%0d_addr", v), ram_address, tbl[v].exp_addr);
      tick();
      chk($sformatf("v%0d_ival", v), i_readdatavalid, tbl[v].exp_iv);
      chk($sformatf("v%0d_dval", v), d_readdatavalid, tbl[v].exp_dv);
      chk($sformatf("v%0d_drop", v), d_write_dropped, tbl[v].exp_drop);
      if (tbl[v].exp_iv) chk($sformatf("v%0d_idata", v), i_readdata, init_word(12'h0AA));
      if (tbl[v].exp_dv) chk($sformatf("v%0d_ddata", v), d_readdata, init_word(12'h155));
    end
    idle_inputs();
    tick();

    // Back-to-back I reads 0x000..0x00F
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) begin
        chk("t1_ival", i_readdatavalid, 1);
        chk("t1_idata", i_readdata, init_word(12'(k - 1)));
      end
      i_read = (k < 16); i_address = 12'(k);
      @(negedge clk);
      if (k < 16) chk("t1_iwait", i_waitrequest, 0);
      tick();
    end
    chk("t1_ival_end", i_readdatavalid, 0);

    // Both masters read continuously: 8 I grants then 1 D grant
    i_read = 1'b1; i_address = 12'h030; d_read = 1'b1; d_address = 12'h020;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      chk($sformatf("t2_iwait_c%0d", c), i_waitrequest, (c % 9 == 8));
      chk($sformatf("t2_dwait_c%0d", c), d_waitrequest, (c % 9 != 8));
      tick();
      if (c % 9 == 8) begin
        chk("t2_dval", d_readdatavalid, 1);
        chk("t2_ddata", d_readdata, init_word(12'h020));
      end else begin
        chk("t2_ival", i_readdatavalid, 1);
        chk("t2_idata", i_readdata, init_word(12'h030));
      end
    end
    idle_inputs();
    tick();

    // Locked image load of 0x100..0x103 while I keeps requesting
    d_write = 1'b1; d_lock = 1'b1; d_byteenable = 4'hF;
    for (int k = 0; k < 4; k++) begin
      i_read = (k > 0); i_address = 12'h040;
      d_address = 12'h100 + 12'(k); d_writedata = 32'hC0DE0000 + k;
      @(negedge clk);
      chk("t3_iwait", i_waitrequest, 1);
      chk("t3_dwait", d_waitrequest, 0);
      chk("t3_addr", ram_address, 12'h100 + 12'(k));
      chk("t3_wr", ram_write, 1);
      tick();
    end
    d_write = 1'b0; d_lock = 1'b0; i_read = 1'b1;
    @(negedge clk);
    chk("t3_unlock_igrant", i_waitrequest, 0);
    tick();
    i_read = 1'b0; d_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d_address = 12'h100 + 12'(k);
      tick();
      chk("t3_rb_val", d_readdatavalid, 1);
      chk("t3_rb_data", d_readdata, 32'hC0DE0000 + k);
    end
    idle_inputs();
    tick();

    // Protected write is accepted but dropped
    ram_wr_protect = 1'b1; d_write = 1'b1; d_address = 12'h200; d_writedata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t4_dwait", d_waitrequest, 0);
    chk("t4_cs", ram_chipselect, 0);
    chk("t4_clken", ram_clken, 0);
    chk("t4_wr", ram_write, 0);
    tick();
    chk("t4_drop", d_write_dropped, 1);
    d_write = 1'b0; ram_wr_protect = 1'b0; d_read = 1'b1;
    tick();
    chk("t4_drop_end", d_write_dropped, 0);
    chk("t4_rb_val", d_readdatavalid, 1);
    chk("t4_rb_data", d_readdata, init_word(12'h200));
    idle_inputs();

    // Byte-lane write
    d_write = 1'b1; d_address = 12'h010; d_writedata = 32'h11223344; d_byteenable = 4'hF;
    tick();
    d_writedata = 32'h0000AB00; d_byteenable = 4'b0010;
    @(negedge clk);
    chk("t5_be", ram_byteenable, 4'b0010);
    tick();
    d_write = 1'b0; d_read = 1'b1; d_byteenable = 4'hF;
    tick();
    chk("t5_rb_val", d_readdatavalid, 1);
    chk("t5_rb_data", d_readdata, 32'h1122AB44);
    idle_inputs();
    tick();

    // Reset right after an I accept discards the pending return
    i_read = 1'b1; i_address = 12'h005;
    tick();
    reset_n = 1'b0;
    #1;
    chk("t6_ival_rst", i_readdatavalid, 0);
    chk("t6_iwait_rst", i_waitrequest, 1);
    chk("t6_cs_rst", ram_chipselect, 0);
    chk("t6_drop_rst", d_write_dropped, 0);
    tick();
    chk("t6_ival_rst2", i_readdatavalid, 0);
    i_read = 1'b0; reset_n = 1'b1;
    tick();
    chk("t6_ival_post", i_readdatavalid, 0);
    i_read = 1'b1; i_address = 12'h007;
    @(negedge clk);
    chk("t6_iwait_post", i_waitrequest, 0);
    tick();
    chk("t6_ival_read", i_readdatavalid, 1);
    chk("t6_idata_read", i_readdata, init_word(12'h007));
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
